// File: rtl/axis_uart_pkg.sv
// Shared UART definitions: receive FSM states, default line parameters and
// counter sizing used by both the transmit and receive paths.
package axis_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // 50 MHz system clock, 115200 baud, 8N1
    localparam int unsigned UART_CLKS_PER_BIT = 434;
    localparam int unsigned UART_DATA_BITS    = 8;

    function automatic int unsigned cnt_width(input int unsigned clks);
        return (clks < 2) ? 1 : $clog2(clks);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous input pin, with a selectable
// reset value so idle-high and idle-low pins both come out of reset quietly.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/axis_uart_rx.sv
// 8N1 UART receiver: samples each bit at its midpoint and presents completed
// bytes through a single-entry AXI-Stream holding register.
module axis_uart_rx
    import axis_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e            state_d,     state_q;
    logic [CNT_W-1:0]     cnt_d,       cnt_q;
    logic [IDX_W-1:0]     bit_idx_d,   bit_idx_q;
    logic [DATA_BITS-1:0] shift_d,     shift_q;
    logic                 rx_prev_d,   rx_prev_q;
    logic [DATA_BITS-1:0] tdata_d,     tdata_q;
    logic                 tvalid_d,    tvalid_q;
    logic                 frame_err_d, frame_err_q;
    logic                 overrun_d,   overrun_q;
    logic                 byte_done;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_prev_d   = rx_s;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        byte_done   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Edge-qualified start: a line stuck low cannot retrigger
                if (!rx_s && rx_prev_q) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!rx_s) begin
                        state_d   = DATA;
                        cnt_d     = FULL_LOAD;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d[bit_idx_q] = rx_s;
                    cnt_d              = FULL_LOAD;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is caught
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (rx_s) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        // A slot is free if empty or being drained this very cycle
        if (byte_done) begin
            if (!tvalid_q || m_axis_tready) begin
                tdata_d  = shift_q;
                tvalid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_prev_q   <= 1'b1;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_prev_q   <= rx_prev_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign frame_err     = frame_err_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_axis_uart_rx.sv
// Bench for axis_uart_rx at 16 clocks per bit: table-driven frames, hand-written
// corner sequences, and random frames checked against a byte-level reference.
module tb_axis_uart_rx;

    localparam int CPB   = 16;
    localparam int DBITS = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx = 1'b1;
    logic [DBITS-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready = 1'b1;
    logic             frame_err;
    logic             overrun;
    logic             busy;

    axis_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DBITS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .frame_err     (frame_err),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Observed events, written only by the monitor below
    logic [7:0] rx_log [0:1023];
    int         rx_n      = 0;
    int         ferr_cnt  = 0;
    int         ovr_cnt   = 0;
    int         busy_cnt  = 0;

    // Inputs change at posedge+1, so negedge sees what the next posedge uses
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_axis_tvalid && m_axis_tready) begin
                rx_log[rx_n[9:0]] = m_axis_tdata;
                rx_n = rx_n + 1;
            end
            if (frame_err) ferr_cnt = ferr_cnt + 1;
            if (overrun)   ovr_cnt  = ovr_cnt + 1;
            if (busy)      busy_cnt = busy_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves rx at the stop-bit level; caller decides what the line does next
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < DBITS; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_bit;
        tick(CPB);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         gap;
        int         exp_bytes;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [0:5];

    int         n0, f0, o0, b0, lat, rd;
    logic       got;
    int         exp_q [$];
    int         exp_ferr;
    logic [7:0] rdata;
    logic       rstop;
    int         rgap;

    initial begin
        vecs[0] = '{8'h00, 1'b1, 0, 1, 8'h00, 0};
        vecs[1] = '{8'hFF, 1'b1, 0, 1, 8'hFF, 0};
        vecs[2] = '{8'h3C, 1'b1, 3, 1, 8'h3C, 0};
        vecs[3] = '{8'hC3, 1'b0, 2, 0, 8'h00, 1};
        vecs[4] = '{8'h7E, 1'b1, 5, 1, 8'h7E, 0};
        vecs[5] = '{8'h01, 1'b1, 0, 1, 8'h01, 0};

        // Reset values
        tick(3);
        check("rst_tvalid", 32'(m_axis_tvalid), 0);
        check("rst_tdata", 32'(m_axis_tdata), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_err", 32'(frame_err), 0);
        check("rst_overrun", 32'(overrun), 0);
        rst_n = 1'b1;
        tick(5);

        // Single frame 0xA5 with latency measurement
        n0 = rx_n; f0 = ferr_cnt; o0 = ovr_cnt;
        lat = 0; got = 1'b0;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                while (!got && lat < 400) begin
                    @(posedge clk);
                    #1;
                    lat++;
                    if (m_axis_tvalid) got = 1'b1;
                end
            end
        join
        check("a5_seen", 32'(got), 1);
        check_range("a5_latency", lat, 154, 157);
        check("a5_count", 32'(rx_n - n0), 1);
        check("a5_data", 32'(rx_log[n0[9:0]]), 32'h A5);
        check("a5_ferr", 32'(ferr_cnt - f0), 0);
        check("a5_ovr", 32'(ovr_cnt - o0), 0);
        check("a5_tvalid_cleared", 32'(m_axis_tvalid), 0);

        // Table: back-to-back frames and a bad stop bit in the middle
        for (int i = 0; i < 6; i++) begin
            n0 = rx_n; f0 = ferr_cnt;
            send_frame(vecs[i].data, vecs[i].stop_bit);
            check($sformatf("vec%0d_count", i), 32'(rx_n - n0), 32'(vecs[i].exp_bytes));
            if (vecs[i].exp_bytes > 0)
                check($sformatf("vec%0d_data", i), 32'(rx_log[n0[9:0]]), 32'(vecs[i].exp_data));
            check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
            if (vecs[i].gap > 0) begin
                rx = 1'b1;
                tick(vecs[i].gap);
            end
        end
        rx = 1'b1;
        tick(2 * CPB);

        // Framing error followed by a long break, then a good frame
        n0 = rx_n; f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h55, 1'b0);
        tick(40 * CPB);
        check("brk_ferr_once", 32'(ferr_cnt - f0), 1);
        check("brk_no_byte", 32'(rx_n - n0), 0);
        check("brk_idle", 32'(busy), 0);
        rx = 1'b1;
        tick(3 * CPB);
        check("brk_release_no_byte", 32'(rx_n - n0), 0);
        check("brk_release_ferr", 32'(ferr_cnt - f0), 1);
        send_frame(8'h12, 1'b1);
        rx = 1'b1;
        tick(2);
        check("brk_next_count", 32'(rx_n - n0), 1);
        check("brk_next_data", 32'(rx_log[n0[9:0]]), 32'h12);
        check("brk_ovr", 32'(ovr_cnt - o0), 0);
        tick(CPB);

        // Start glitch
        n0 = rx_n; f0 = ferr_cnt; o0 = ovr_cnt; b0 = busy_cnt;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(2 * CPB);
        check_range("glitch_busy_cycles", busy_cnt - b0, 1, CPB - 1);
        check("glitch_busy_low", 32'(busy), 0);
        check("glitch_no_byte", 32'(rx_n - n0), 0);
        check("glitch_no_ferr", 32'(ferr_cnt - f0), 0);
        check("glitch_no_ovr", 32'(ovr_cnt - o0), 0);

        // Overrun with downstream stalled
        m_axis_tready = 1'b0;
        n0 = rx_n; f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h11, 1'b1);
        check("ovr_first_valid", 32'(m_axis_tvalid), 1);
        check("ovr_first_data", 32'(m_axis_tdata), 32'h11);
        send_frame(8'h22, 1'b1);
        rx = 1'b1;
        tick(2);
        check("ovr_pulse_once", 32'(ovr_cnt - o0), 1);
        check("ovr_keep_valid", 32'(m_axis_tvalid), 1);
        check("ovr_keep_data", 32'(m_axis_tdata), 32'h11);
        check("ovr_no_ferr", 32'(ferr_cnt - f0), 0);
        check("ovr_no_handshake", 32'(rx_n - n0), 0);
        m_axis_tready = 1'b1;
        tick(1);
        check("ovr_accept_count", 32'(rx_n - n0), 1);
        check("ovr_accept_data", 32'(rx_log[n0[9:0]]), 32'h11);
        check("ovr_valid_cleared", 32'(m_axis_tvalid), 0);
        tick(CPB);

        // Reset during data bit 4
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            tick(CPB);
        end
        rx = 1'b1;
        tick(CPB / 2);
        check("mid_busy_before_rst", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 0);
        check("mid_rst_tdata", 32'(m_axis_tdata), 0);
        check("mid_rst_ferr", 32'(frame_err), 0);
        check("mid_rst_ovr", 32'(overrun), 0);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        n0 = rx_n; f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h81, 1'b1);
        rx = 1'b1;
        tick(3 * CPB);
        check("post_rst_count", 32'(rx_n - n0), 1);
        check("post_rst_data", 32'(rx_log[n0[9:0]]), 32'h81);
        check("post_rst_ferr", 32'(ferr_cnt - f0), 0);
        check("post_rst_ovr", 32'(ovr_cnt - o0), 0);

        // Random frames against a byte-level reference
        n0 = rx_n; f0 = ferr_cnt; o0 = ovr_cnt;
        exp_ferr = 0;
        for (int i = 0; i < 30; i++) begin
            rdata = 8'($urandom);
            rstop = ($urandom_range(0, 5) != 0);
            rgap  = $urandom_range(2, 20);
            if (rstop) exp_q.push_back(int'(rdata));
            else       exp_ferr++;
            send_frame(rdata, rstop);
            rx = 1'b1;
            tick(rgap);
        end
        tick(2 * CPB);
        check("rand_count", 32'(rx_n - n0), 32'(exp_q.size()));
        check("rand_ferr", 32'(ferr_cnt - f0), 32'(exp_ferr));
        check("rand_ovr", 32'(ovr_cnt - o0), 0);
        rd = n0;
        while (exp_q.size() > 0 && rd < rx_n) begin
            check($sformatf("rand_byte%0d", rd - n0), 32'(rx_log[rd[9:0]]), 32'(exp_q.pop_front()));
            rd++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
